// File: rtl/pipe_reg_if_id_skid.sv
// IF/ID pipeline register with a 2-entry skid buffer so in_ready comes from a flop.
// Optional stall/flush counters are built only when PIPE_PERF_EN is defined.
module pipe_reg_if_id_skid #(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter logic [ILEN-1:0] BUBBLE_INST = ILEN'(32'h00000013),
    parameter logic [XLEN-1:0] BUBBLE_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_if,
    input  logic [ILEN-1:0] inst_if,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            do_stall,
    input  logic            br,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] pc_id,
    output logic [ILEN-1:0] inst_id
`ifdef PIPE_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } state_t;

    state_t          state;
    logic [XLEN-1:0] skid_pc;
    logic [ILEN-1:0] skid_inst;
    logic            acc;
    logic            drn;

    assign acc = in_valid & in_ready;
    assign drn = id_valid & id_ready & ~do_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            id_valid  <= 1'b0;
            in_ready  <= 1'b1;
            pc_id     <= BUBBLE_PC;
            inst_id   <= BUBBLE_INST;
            skid_pc   <= '0;
            skid_inst <= '0;
        end else if (br) begin
            // Anything held or offered this cycle is wrong-path.
            state    <= EMPTY;
            id_valid <= 1'b0;
            in_ready <= 1'b1;
            pc_id    <= BUBBLE_PC;
            inst_id  <= BUBBLE_INST;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        state    <= FULL;
                        id_valid <= 1'b1;
                        pc_id    <= pc_if;
                        inst_id  <= inst_if;
                    end
                end
                FULL: begin
                    if (acc && drn) begin
                        pc_id   <= pc_if;
                        inst_id <= inst_if;
                    end else if (acc) begin
                        state     <= SKID;
                        in_ready  <= 1'b0;
                        skid_pc   <= pc_if;
                        skid_inst <= inst_if;
                    end else if (drn) begin
                        state    <= EMPTY;
                        id_valid <= 1'b0;
                        pc_id    <= BUBBLE_PC;
                        inst_id  <= BUBBLE_INST;
                    end
                end
                SKID: begin
                    if (drn) begin
                        state    <= FULL;
                        in_ready <= 1'b1;
                        pc_id    <= skid_pc;
                        inst_id  <= skid_inst;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    id_valid <= 1'b0;
                    in_ready <= 1'b1;
                    pc_id    <= BUBBLE_PC;
                    inst_id  <= BUBBLE_INST;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    // Saturating counters; a flush only counts when it discards something.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (id_valid && do_stall && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (br && state != EMPTY && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg_if_id_skid.sv
// Self-checking bench for pipe_reg_if_id_skid against a queue-based occupancy model.
// Counter checks are compiled in when PIPE_PERF_EN is defined.
module tb_pipe_reg_if_id_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_if;
    logic [31:0] inst_if;
    logic        in_valid;
    logic        in_ready;
    logic        do_stall;
    logic        br;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] pc_id;
    logic [31:0] inst_id;
`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipe_reg_if_id_skid dut (
        .clk      (clk),
        .reset    (reset),
        .pc_if    (pc_if),
        .inst_if  (inst_if),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .do_stall (do_stall),
        .br       (br),
        .id_ready (id_ready),
        .id_valid (id_valid),
        .pc_id    (pc_id),
        .inst_id  (inst_id)
`ifdef PIPE_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } beat_t;

    // Model: the stage is just an ordered list of held beats (at most 2).
    beat_t       q[$];
    int unsigned m_stall;
    int unsigned m_flush;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [65:0] got;
    logic [65:0] exp;
    localparam logic [65:0] EMPTY_OUT = {1'b0, 1'b1, 32'h0, 32'h0000_0013};

    assign got = {id_valid, in_ready, pc_id, inst_id};

    function automatic logic [65:0] model_out();
        if (q.size() == 0)
            return EMPTY_OUT;
        return {1'b1, q.size() < 2, q[0].pc, q[0].inst};
    endfunction

    task automatic tick(input logic v, input logic [31:0] pc,
                        input logic [31:0] inst, input logic st,
                        input logic b, input logic rdy, input logic rst);
        logic acc;
        logic drn;
        in_valid = v;
        pc_if    = pc;
        inst_if  = inst;
        do_stall = st;
        br       = b;
        id_ready = rdy;
        reset    = rst;
        acc = v && (q.size() < 2);
        drn = (q.size() > 0) && rdy && !st;
        if (rst) begin
            q.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (q.size() > 0 && st && m_stall != 32'hFFFF_FFFF)
                m_stall++;
            if (b && q.size() > 0 && m_flush != 32'hFFFF_FFFF)
                m_flush++;
            if (b) begin
                q.delete();
            end else begin
                if (drn)
                    void'(q.pop_front());
                if (acc)
                    q.push_back(beat_t'{pc, inst});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        tick(1'b0, 32'hDEAD_BEEF, 32'hBAAD_F00D, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic test_reset();
        tick(1'b1, 32'h1234, 32'h5678, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (got !== EMPTY_OUT) begin
            n_fail++;
            $display("FAIL reset_out got=%h exp=%h", got, EMPTY_OUT);
        end
`ifdef PIPE_PERF_EN
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
`endif
    endtask

    task automatic test_stream();
        logic [31:0] insts [4];
        insts[0] = 32'h0050_0093;
        insts[1] = 32'h0060_0113;
        insts[2] = 32'h0070_0193;
        insts[3] = 32'h0080_0213;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 32'(i * 4), insts[i], 1'b0, 1'b0, 1'b1, 1'b0);
            exp = {1'b1, 1'b1, 32'(i * 4), insts[i]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL stream_%0d got=%h exp=%h", i, got, exp);
            end
        end
        idle(1'b1);
        n_checks++;
        if (got !== EMPTY_OUT) begin
            n_fail++;
            $display("FAIL stream_drain got=%h exp=%h", got, EMPTY_OUT);
        end
    endtask

    task automatic test_stall_skid();
        tick(1'b1, 32'h10, 32'h0010_0013, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'($urandom), 1'b0);
            n_checks++;
            if (pc_id !== 32'h10 || id_valid !== 1'b1 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold_%0d got=%h exp_pc=10", i, got);
            end
        end
        tick(1'b1, 32'h14, 32'h0014_0013, 1'b1, 1'b0, 1'b1, 1'b0);
        exp = {1'b1, 1'b0, 32'h10, 32'h0010_0013};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL stall_skid got=%h exp=%h", got, exp);
        end
        idle(1'b1);
        exp = {1'b1, 1'b1, 32'h14, 32'h0014_0013};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL stall_release got=%h exp=%h", got, exp);
        end
        idle(1'b1);
        n_checks++;
        if (got !== EMPTY_OUT) begin
            n_fail++;
            $display("FAIL stall_drain got=%h exp=%h", got, EMPTY_OUT);
        end
    endtask

    task automatic test_flush_skid();
        tick(1'b1, 32'h20, 32'h0020_0013, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'h24, 32'h0024_0013, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_fill in_ready got=%b exp=0", in_ready);
        end
        tick(1'b1, 32'h28, 32'h0028_0013, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (got !== EMPTY_OUT) begin
            n_fail++;
            $display("FAIL flush_out got=%h exp=%h", got, EMPTY_OUT);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            n_checks++;
            if (got !== EMPTY_OUT) begin
                n_fail++;
                $display("FAIL flush_after_%0d got=%h exp=%h", i, got, EMPTY_OUT);
            end
        end
    endtask

    task automatic test_hold_no_stall();
        tick(1'b1, 32'h30, 32'h0030_0013, 1'b0, 1'b0, 1'b0, 1'b0);
        exp = {1'b1, 1'b1, 32'h30, 32'h0030_0013};
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL hold_%0d got=%h exp=%h", i, got, exp);
            end
        end
        idle(1'b1);
        n_checks++;
        if (got !== EMPTY_OUT) begin
            n_fail++;
            $display("FAIL hold_drain got=%h exp=%h", got, EMPTY_OUT);
        end
    endtask

    task automatic test_reset_in_skid();
        tick(1'b1, 32'h50, 32'h0050_0013, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'h54, 32'h0054_0013, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 32'h58, 32'h0058_0013, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (got !== EMPTY_OUT) begin
            n_fail++;
            $display("FAIL rst_skid got=%h exp=%h", got, EMPTY_OUT);
        end
`ifdef PIPE_PERF_EN
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_skid_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
`endif
    endtask

`ifdef PIPE_PERF_EN
    task automatic test_perf();
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 32'h40, 32'h0040_0013, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 32'h44, 32'h0044_0013, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (stall_cnt !== 32'd5) begin
            n_fail++;
            $display("FAIL perf_stall got=%0d exp=5", stall_cnt);
        end
        n_checks++;
        if (flush_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_flush got=%0d exp=2", flush_cnt);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
            exp = model_out();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rand_%0d got=%h exp=%h", i, got, exp);
            end
`ifdef PIPE_PERF_EN
            n_checks++;
            if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
                n_fail++;
                $display("FAIL rand_cnt_%0d got=%0d/%0d exp=%0d/%0d",
                         i, stall_cnt, flush_cnt, m_stall, m_flush);
            end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        m_stall = 0;
        m_flush = 0;
        test_reset();
        test_stream();
        test_stall_skid();
        test_flush_skid();
        test_hold_no_stall();
        test_reset_in_skid();
`ifdef PIPE_PERF_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_reg_if_id_skid.md
Name: pipe_reg_if_id_skid

Overview:
Parametrised successor to the plain IF/ID latch. Registers fetch-stage PC and instruction into decode, with a valid/ready handshake, a hazard-unit stall and a branch flush. A 2-entry skid buffer (main + skid) lets `in_ready` be driven from a flop, so no combinational ready path runs back into fetch. Sits between the fetch unit / I-mem and the decode stage.

Parameters:
XLEN, 32, width of the PC field
ILEN, 32, width of the instruction field
BUBBLE_INST, 32'h00000013, instruction driven on `inst_id` when no valid beat is held (addi x0,x0,0)
BUBBLE_PC, 0, PC value driven on `pc_id` when no valid beat is held

Ports:
clk  in  1  clock, rising-edge
reset  in  1  synchronous, active-high
pc_if  in  XLEN  fetch PC
inst_if  in  ILEN  fetched instruction
in_valid  in  1  fetch beat valid
in_ready  out  1  stage can accept a beat (registered)
do_stall  in  1  hazard unit holds decode; blocks drain
br  in  1  taken branch/jump; flush stage
id_ready  in  1  decode can consume
id_valid  out  1  `pc_id`/`inst_id` hold a real instruction
pc_id  out  XLEN  PC to decode
inst_id  out  ILEN  instruction to decode
stall_cnt  out  32  (PIPE_PERF_EN only) stall-cycle count
flush_cnt  out  32  (PIPE_PERF_EN only) flush count

Behaviour:
- Definitions:
  - acc = in_valid & in_ready
  - drn = id_valid & id_ready & ~do_stall
- All state updates occur on posedge clk.
- Priority order: reset > br > normal.
- Reset values: id_valid=0, in_ready=1, pc_id=BUBBLE_PC, inst_id=BUBBLE_INST, skid empty, state=EMPTY, counters=0.
- States (2-bit encoded): EMPTY (main invalid), FULL (main valid, skid empty), SKID (main and skid valid).
- EMPTY:
  - acc -> FULL; main <= inputs.
  - else stay.
- FULL:
  - acc & drn -> FULL; main <= inputs.
  - acc & ~drn -> SKID; skid <= inputs; main unchanged.
  - ~acc & drn -> EMPTY; main data <= bubble values.
  - else hold.
- SKID:
  - in_ready=0, so no acceptance.
  - drn -> FULL; main <= skid.
  - else hold.
- Ready and valid outputs:
  - in_ready next-state = (next state != SKID).
  - id_valid = (state != EMPTY), registered.
- Latency and throughput:
  - 1 cycle: a beat accepted at edge N is visible on pc_id/inst_id after edge N.
  - Full throughput, 1 beat/cycle, while drn holds.
- Stall: do_stall=1 freezes main regardless of id_ready. Upstream may still fill the skid (FULL->SKID), after which in_ready drops the next cycle.
- Flush (br=1):
  - Next state EMPTY; main and skid invalidated; pc_id/inst_id <= bubble values; in_ready <= 1.
  - A beat accepted in the same cycle as br is discarded (wrong path).
  - No beat is counted as drained in the flush cycle.
- Reset mid-operation behaves exactly as a flush and also clears the counters.
- Data outputs never change while id_valid=1 and drn=0.
- No X propagation: skid contents are don't-care only while the skid is invalid; the outputs always carry either real data or bubble values.

Optional Feature:
Macro PIPE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with id_valid & do_stall.
  - flush_cnt increments each cycle br=1 while state != EMPTY.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: both ports and all counter logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then stream 4 beats (pc 0x00,0x04,0x08,0x0C; inst 0x00500093…) with id_ready=1 -> each appears 1 cycle later; id_valid=1 throughout; in_ready stays 1.
- FULL holding pc 0x10, do_stall=1 for 3 cycles, then beat pc 0x14 offered -> pc 0x14 goes to skid; in_ready=0 the next cycle; pc_id stays 0x10 while stalled. Release -> 0x10 consumed, then 0x14 appears; in_ready returns to 1.
- SKID state, br=1 with in_valid=1 -> next cycle id_valid=0, inst_id=0x00000013, pc_id=0, in_ready=1; neither buffered beat nor the offered beat is ever output.
- id_ready=0 with do_stall=0 at FULL, no new input -> outputs held; then id_ready=1 -> EMPTY with bubble outputs.
- reset asserted while in SKID -> same result as the flush case; with PIPE_PERF_EN, counters read 0.
- PIPE_PERF_EN: 5 stall cycles while valid, plus 2 flushes on a non-empty stage -> stall_cnt=5, flush_cnt=2; a flush while EMPTY does not increment flush_cnt.
